mmcm_reset_sequencer: RTL and testbench
=======================================

// Module: mmcm_reset_sequencer
// PURPOSE
//  Drives the MMCM RST input and qualifies its LOCKED output: pulses RST, waits for lock
//  with timeout and retry, and requires lock to hold continuously before releasing
//  sys_reset. Runs on the free-running buffered 200 MHz input clock, upstream of the
//  MMCM, so it never depends on MMCM outputs. sys_reset feeds the per-domain reset
//  synchronizers in place of raw ~LOCKED.
// PARAMETERS
//  RST_HOLD_CYCLES      16     cycles mmcm_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT_CYCLES  65536  max cycles in WAIT_LOCK before the attempt fails
//  STABLE_CYCLES        256    consecutive locked cycles required before release
//  MAX_RETRIES          4      failed attempts allowed before entering FAIL (>=1)
// PORTS
//  clk           in   1  free-running 200 MHz buffered input clock
//  reset_n       in   1  asynchronous, active-low reset
//  lock_in       in   1  MMCM LOCKED; asynchronous to clk
//  sw_reset_req  in   1  single-cycle request to restart sequencing
//  mmcm_rst      out  1  to MMCM RST
//  sys_reset     out  1  high until clocks are qualified
//  fail          out  1  retries exhausted; sticky until sw_reset_req
//  retry_count   out  8  failed attempts in current sequence; saturates at 255
//  relock_count  out  8  lock losses seen in RUN since reset; saturates at 255
// BEHAVIOUR
//  - Reset values: mmcm_rst=1, sys_reset=1, fail=0, retry_count=0, relock_count=0,
//    state=HOLD, counter=0.
//  - lock_in passes through a 2-flop synchronizer. lock_s is 2 cycles late; all
//    decisions use lock_s.
//  - HOLD: mmcm_rst=1. Stay RST_HOLD_CYCLES cycles, then go to WAIT_LOCK with counter=0.
//  - WAIT_LOCK: mmcm_rst=0.
//    - lock_s=1 -> STABLE.
//    - counter reaches LOCK_TIMEOUT_CYCLES-1 -> attempt failed.
//  - STABLE: mmcm_rst=0.
//    - lock_s=0 -> attempt failed.
//    - STABLE_CYCLES consecutive lock_s=1 -> RUN.
//  - Attempt failed: retry_count+1. If the new value equals MAX_RETRIES -> FAIL,
//    otherwise -> HOLD.
//  - RUN: sys_reset=0 (registered; deasserts the cycle RUN is entered).
//    - lock_s=0: relock_count+1 and sys_reset=1 in the same cycle; then see CONFIGURATION.
//  - FAIL: mmcm_rst=0, sys_reset=1, fail=1. Leave only on sw_reset_req.
//  - sw_reset_req in any state -> HOLD; retry_count=0, fail=0, counter=0. It has
//    priority over every same-cycle transition.
//  - sys_reset=1 in every state except RUN. Counters never wrap; their width is
//    $clog2 of the largest parameter.
//  - reset_n asserted mid-operation: all registers immediately return to reset values.
// CONFIGURATION
//  LOCK_LOSS_AUTORESET_EN defined: lock loss in RUN -> HOLD with retry_count=0
//    (automatic re-sequence).
//  Not defined: lock loss in RUN -> FAIL (fail=1, mmcm_rst=0); firmware restarts the
//    sequence via sw_reset_req.
// STRUCTURE
//  mmcm_reseq_pkg: state enum {HOLD, WAIT_LOCK, STABLE, RUN, FAIL}, counter width
//    function, saturating-increment function.
//  Sub-module lock_sync: 2-flop synchronizer with async active-low reset to 0,
//    ASYNC_REG attribute.
// TESTING (bench params: RST_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, STABLE_CYCLES=8,
//  MAX_RETRIES=3)
//  1 Release reset_n, raise lock_in at cycle 10 ->
//    - mmcm_rst high for cycles 0-3;
//    - sys_reset falls exactly 2+8 cycles after lock_in, plus FSM latency; check cycle-exact.
//  2 lock_in held at 0 ->
//    - 3 timeouts (retry_count 1,2,3);
//    - fail=1 and mmcm_rst=0 at the third timeout; no further mmcm_rst pulses.
//  3 lock_in glitches low for 3 cycles mid-STABLE ->
//    - retry_count=1, mmcm_rst re-pulses;
//    - stable count restarts from 0 on relock.
//  4 In RUN, drop lock_in ->
//    - sys_reset=1 and relock_count=1;
//    - with _EN: mmcm_rst pulses, then returns to RUN;
//    - without _EN: fail=1 and the block stays in FAIL.
//  5 sw_reset_req in FAIL and in RUN ->
//    - mmcm_rst=1 next cycle, fail=0, retry_count=0;
//    - sw_reset_req coincident with STABLE completion -> HOLD wins.
//  6 Assert reset_n low mid-WAIT_LOCK, asynchronously ->
//    - outputs at reset values before the next clk edge;
//    - relock_count at 255 does not wrap after a further lock loss.

Source files
------------

// File: rtl/mmcm_reset_sequencer_pkg.sv
// mmcm_reseq_pkg: shared state encoding and helpers for mmcm_reset_sequencer.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

package mmcm_reseq_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  // Width of the shared cycle counter: wide enough for the largest interval.
  function automatic int cnt_width(int unsigned a, int unsigned b,
                                   int unsigned c, int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic logic [7:0] sat_inc8(logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmcm_reset_sequencer_if.sv
// mmcm_reset_sequencer_if: MMCM control/status bundle between sequencer and its users.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

interface mmcm_reset_sequencer_if;
  logic       lock_in;
  logic       sw_reset_req;
  logic       mmcm_rst;
  logic       sys_reset;
  logic       fail;
  logic [7:0] retry_count;
  logic [7:0] relock_count;

  modport master (
    input  lock_in, sw_reset_req,
    output mmcm_rst, sys_reset, fail, retry_count, relock_count
  );

  modport slave (
    output lock_in, sw_reset_req,
    input  mmcm_rst, sys_reset, fail, retry_count, relock_count
  );
endinterface

`default_nettype wire

// File: rtl/mmcm_reset_sequencer_lock_sync.sv
// lock_sync: two-flop synchronizer for MMCM LOCKED, async active-low reset to 0.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module lock_sync (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic async_in,
  output logic      sync_out
);

  (* ASYNC_REG = "TRUE" *) logic [1:0] sync_ff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_ff <= 2'b00;
    else          sync_ff <= {sync_ff[0], async_in};
  end

  assign sync_out = sync_ff[1];

endmodule

`default_nettype wire

// File: rtl/mmcm_reset_sequencer.sv
// mmcm_reset_sequencer: pulses MMCM RST, qualifies LOCKED with timeout/retry and hold-off,
// then releases sys_reset. Option macro: LOCK_LOSS_AUTORESET_EN. Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module mmcm_reset_sequencer
  import mmcm_reseq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned STABLE_CYCLES       = 256,
  parameter int unsigned MAX_RETRIES         = 4
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  mmcm_reset_sequencer_if.master bus
);

  localparam int CW = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES,
                                STABLE_CYCLES, MAX_RETRIES);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [7:0]    RETRY_LIMIT  = 8'(MAX_RETRIES);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    retry, retry_nxt;
  logic [7:0]    relock, relock_nxt;
  logic          attempt_fail;
  logic          lock_s;
  logic          mmcm_rst_q, sys_reset_q, fail_q;

  lock_sync u_lock_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (bus.lock_in),
    .sync_out (lock_s)
  );

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    retry_nxt    = retry;
    relock_nxt   = relock;
    attempt_fail = 1'b0;

    case (state)
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          attempt_fail = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          attempt_fail = 1'b1;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          relock_nxt = sat_inc8(relock);
          cnt_nxt    = '0;
`ifdef LOCK_LOSS_AUTORESET_EN
          state_nxt  = HOLD;
          retry_nxt  = '0;
`else
          state_nxt  = FAIL;
`endif
        end
      end
      FAIL: begin
        state_nxt = FAIL;
      end
      default: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
    endcase

    if (attempt_fail) begin
      retry_nxt = sat_inc8(retry);
      cnt_nxt   = '0;
      state_nxt = (retry_nxt == RETRY_LIMIT) ? FAIL : HOLD;
    end

    // Firmware restart overrides whatever the FSM decided this cycle.
    if (bus.sw_reset_req) begin
      state_nxt = HOLD;
      retry_nxt = '0;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HOLD;
      cnt         <= '0;
      retry       <= '0;
      relock      <= '0;
      mmcm_rst_q  <= 1'b1;
      sys_reset_q <= 1'b1;
      fail_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry       <= retry_nxt;
      relock      <= relock_nxt;
      mmcm_rst_q  <= (state_nxt == HOLD);
      sys_reset_q <= (state_nxt != RUN);
      fail_q      <= (state_nxt == FAIL);
    end
  end

  assign bus.mmcm_rst     = mmcm_rst_q;
  assign bus.sys_reset    = sys_reset_q;
  assign bus.fail         = fail_q;
  assign bus.retry_count  = retry;
  assign bus.relock_count = relock;

endmodule

`default_nettype wire

// File: tb/tb_mmcm_reset_sequencer.sv
// tb_mmcm_reset_sequencer: table-driven directed checks for mmcm_reset_sequencer.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_mmcm_reset_sequencer;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  mmcm_reset_sequencer_if bus ();

  mmcm_reset_sequencer #(
    .RST_HOLD_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .STABLE_CYCLES       (8),
    .MAX_RETRIES         (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    at;
    bit    lock;
    bit    sw;
    bit    rst;
    bit    sys;
    bit    fl;
    int    retry;
    int    relock;
    string nm;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int at, bit lock, bit sw, bit rst, bit sys, bit fl,
                              int retry, int relock, string nm);
    vec_t v;
    v.at = at; v.lock = lock; v.sw = sw; v.rst = rst; v.sys = sys; v.fl = fl;
    v.retry = retry; v.relock = relock; v.nm = nm;
    vecs.push_back(v);
  endfunction

  function automatic int pk(bit r, bit s, bit f, int retry, int relock);
    logic [7:0] rt, rl;
    rt = retry[7:0];
    rl = relock[7:0];
    return {13'b0, r, s, f, rt, rl};
  endfunction

  function automatic int outs();
    return {13'b0, bus.mmcm_rst, bus.sys_reset, bus.fail, bus.retry_count, bus.relock_count};
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1 bus.sw_reset_req = 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    bus.lock_in      = 1'b0;
    bus.sw_reset_req = 1'b0;
    reset_n          = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  // Vector semantics: at cycle 'at' compare outputs, then drive lock/sw for what follows.
  task automatic run_vecs();
    foreach (vecs[i]) begin
      while (cyc < vecs[i].at) tick();
      chk(vecs[i].nm, outs(),
          pk(vecs[i].rst, vecs[i].sys, vecs[i].fl, vecs[i].retry, vecs[i].relock));
      bus.lock_in      = vecs[i].lock;
      bus.sw_reset_req = vecs[i].sw;
    end
    vecs.delete();
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (bus.sys_reset && n < 100) begin
      tick();
      n++;
    end
    chk("wait_run", int'(bus.sys_reset), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;

    // Lock-up, release timing, lock loss in RUN, restart from RUN
    do_reset();
    add(0,  0, 0, 1, 1, 0, 0, 0, "s1_reset");
    add(3,  0, 0, 1, 1, 0, 0, 0, "s1_hold_end");
    add(4,  0, 0, 0, 1, 0, 0, 0, "s1_wait_lock");
    add(10, 1, 0, 0, 1, 0, 0, 0, "s1_lock_raise");
    add(20, 1, 0, 0, 1, 0, 0, 0, "s1_pre_release");
    add(21, 1, 0, 0, 0, 0, 0, 0, "s1_release");
    add(30, 0, 0, 0, 0, 0, 0, 0, "s4_run");
    add(32, 0, 0, 0, 0, 0, 0, 0, "s4_sync_delay");
`ifdef LOCK_LOSS_AUTORESET_EN
    add(33, 1, 0, 1, 1, 0, 0, 1, "s4_loss_autoreset");
    add(36, 1, 0, 1, 1, 0, 0, 1, "s4_hold_end");
    add(37, 1, 0, 0, 1, 0, 0, 1, "s4_wait");
    add(45, 1, 0, 0, 1, 0, 0, 1, "s4_pre_rerun");
    add(46, 1, 0, 0, 0, 0, 0, 1, "s4_rerun");
`else
    add(33, 1, 0, 0, 1, 1, 0, 1, "s4_loss_fail");
    add(50, 1, 1, 0, 1, 1, 0, 1, "s4_fail_sticky");
    add(51, 1, 0, 1, 1, 0, 0, 1, "s5_sw_in_fail");
    add(63, 1, 0, 0, 1, 0, 0, 1, "s5_pre_rerun");
`endif
    add(64, 1, 0, 0, 0, 0, 0, 1, "s4_run_again");
    add(70, 1, 1, 0, 0, 0, 0, 1, "s5_run_sw");
    add(71, 1, 0, 1, 1, 0, 0, 1, "s5_sw_in_run");
    run_vecs();

    // Glitch mid-STABLE: retry and full re-qualification
    do_reset();
    add(0,  0, 0, 1, 1, 0, 0, 0, "s3_reset");
    add(10, 1, 0, 0, 1, 0, 0, 0, "s3_lock_raise");
    add(15, 0, 0, 0, 1, 0, 0, 0, "s3_glitch_start");
    add(17, 0, 0, 0, 1, 0, 0, 0, "s3_glitch_seen");
    add(18, 1, 0, 1, 1, 0, 1, 0, "s3_retry_pulse");
    add(21, 1, 0, 1, 1, 0, 1, 0, "s3_hold_end");
    add(22, 1, 0, 0, 1, 0, 1, 0, "s3_wait");
    add(30, 1, 0, 0, 1, 0, 1, 0, "s3_stable_restart");
    add(31, 1, 0, 0, 0, 0, 1, 0, "s3_release");
    run_vecs();

    // sw_reset_req coincident with STABLE completion
    do_reset();
    add(0,  0, 0, 1, 1, 0, 0, 0, "s5b_reset");
    add(10, 1, 0, 0, 1, 0, 0, 0, "s5b_lock_raise");
    add(20, 1, 1, 0, 1, 0, 0, 0, "s5b_stable_done");
    add(21, 1, 0, 1, 1, 0, 0, 0, "s5b_hold_wins");
    add(25, 1, 0, 0, 1, 0, 0, 0, "s5b_wait");
    add(33, 1, 0, 0, 1, 0, 0, 0, "s5b_pre_run");
    add(34, 1, 0, 0, 0, 0, 0, 0, "s5b_run");
    run_vecs();

    // Lock never arrives: timeouts, FAIL, no further pulses, restart from FAIL
    do_reset();
    add(0,   0, 0, 1, 1, 0, 0, 0, "s2_reset");
    add(35,  0, 0, 0, 1, 0, 0, 0, "s2_wait_end");
    add(36,  0, 0, 1, 1, 0, 1, 0, "s2_timeout1");
    add(71,  0, 0, 0, 1, 0, 1, 0, "s2_wait2_end");
    add(72,  0, 0, 1, 1, 0, 2, 0, "s2_timeout2");
    add(107, 0, 0, 0, 1, 0, 2, 0, "s2_pre_fail");
    add(108, 0, 0, 0, 1, 1, 3, 0, "s2_fail");
    run_vecs();
    pulses = 0;
    repeat (40) begin
      tick();
      if (bus.mmcm_rst) pulses++;
    end
    chk("s2_no_repulse", pulses, 0);
    add(150, 0, 1, 0, 1, 1, 3, 0, "s2_fail_sticky");
    add(151, 0, 0, 1, 1, 0, 0, 0, "s2_sw_in_fail");
    run_vecs();

    // Relock counter saturation, then async reset mid-WAIT_LOCK
    do_reset();
    bus.lock_in = 1'b1;
    wait_run();
    for (int i = 0; i < 256; i++) begin
      bus.lock_in = 1'b0;
      repeat (3) tick();
      if (i == 0)   chk("s6_first_loss", {31'b0, bus.sys_reset}, 1);
      if (i == 254) chk("s6_relock_255", int'(bus.relock_count), 255);
      if (i == 255) chk("s6_relock_sat", int'(bus.relock_count), 255);
      if (i < 255) begin
        bus.lock_in      = 1'b1;
        bus.sw_reset_req = 1'b1;
        tick();
        wait_run();
      end
    end
    bus.sw_reset_req = 1'b1;
    repeat (45) tick();
    chk("s6_pre_reset", outs(), pk(0, 1, 0, 1, 255));
    #2 reset_n = 1'b0;
    #1 chk("s6_async_reset", outs(), pk(1, 1, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
